reorder_fifo: RTL and testbench
===============================

REORDER_FIFO -- requirements
Module: reorder_fifo

Interface
REQ-001 SHALL have parameter width, default 8, data bits per entry.
REQ-002 SHALL have parameter depth, default 4, entry count; any integer >= 2, not restricted to powers of two.
REQ-003 SHALL derive tag_w = $clog2(depth) and cnt_w = $clog2(depth+1) locally.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have alloc_valid  input  1  request to allocate one in-order entry.
REQ-007 SHALL have alloc_ready  output  1  allocation accepted this cycle; equals !full.
REQ-008 SHALL have alloc_tag  output  tag_w  tag of the slot an accepted allocation receives; equals tail pointer.
REQ-009 SHALL have cpl_valid  input  1  out-of-order completion strobe.
REQ-010 SHALL have cpl_tag  input  tag_w  entry being completed.
REQ-011 SHALL have cpl_data  input  width  result data for cpl_tag.
REQ-012 SHALL have cpl_err  output  1  registered one-cycle pulse: previous completion was illegal.
REQ-013 SHALL have out_valid  output  1  head entry allocated and completed.
REQ-014 SHALL have out_ready  input  1  consumer accepts head entry.
REQ-015 SHALL have out_data  output  width  head entry data, combinational from storage.
REQ-016 SHALL have out_tag  output  tag_w  head pointer.
REQ-017 SHALL have count  output  cnt_w  registered occupancy (allocated, not retired).
REQ-018 SHALL have empty and full, both output, 1 bit, registered.

Function
REQ-019 SHALL accept an allocation when alloc_valid && alloc_ready: mark slot alloc_tag pending (done=0); advance tail.
REQ-020 SHALL wrap head and tail from depth-1 to 0 explicitly, also when depth is not a power of two.
REQ-021 SHALL treat a completion as legal only if cpl_tag < depth, the slot is allocated, and done=0.
REQ-022 SHALL, on a legal completion, write cpl_data to the slot and set done=1 at the next edge.
REQ-023 SHALL ignore illegal completions (no state change) and assert cpl_err for exactly the next cycle.
REQ-024 SHALL drive out_valid = !empty && done[head], from registered state only; completion-to-out_valid latency is 1 cycle.
REQ-025 SHALL retire on out_valid && out_ready: clear done[head]; advance head.
REQ-026 SHALL hold out_data and out_tag stable while out_valid && !out_ready.
REQ-027 SHALL update count: +1 on alloc only, -1 on retire only, unchanged on both or neither.
REQ-028 SHALL set full when count reaches depth and empty when count reaches 0; both from the next-state count.
REQ-029 SHALL refuse allocation when full even if a retire occurs in the same cycle; no pass-through.
REQ-030 SHALL allow allocation, completion of a different slot, and retirement in one cycle, with all three effects applied.
REQ-031 SHALL treat completion of the head slot in the retiring cycle as impossible: done[head]=1 already makes the completion illegal.

Reset
REQ-032 SHALL, on rst high at posedge, set head=0, tail=0, count=0, empty=1, full=0, all done=0, cpl_err=0.
REQ-033 SHALL give reset priority over any simultaneous alloc, cpl or retire; mid-operation reset discards all entries.
REQ-034 SHALL leave the data storage array unreset; out_data is don't-care while out_valid=0.

Structure
REQ-035 SHALL need no shared package; all widths derive from parameters inside the module.
REQ-036 SHALL instantiate the head and tail pointers as two copies of one sub-module, wrap_ptr (parameter depth; inputs inc, clr; output ptr), with modulo-depth increment.
REQ-037 SHALL hold done bits in a depth-bit register vector and data in a width x depth array written only on legal completions.

Verification
REQ-038 Depth 4: allocate 4 (tags 0,1,2,3) -> full=1, alloc_ready=0, count=4.
REQ-039 Complete tags 2,0,3,1 with data 0x22,0x00,0x33,0x11; out_ready=1 -> out_data order 0x00,0x11,0x22,0x33; first out_valid 1 cycle after tag 0 completes.
REQ-040 Complete tag 1 twice -> second completion raises cpl_err for one cycle; data keeps first value.
REQ-041 Full FIFO, head done, out_ready=1, alloc_valid=1 -> retire occurs, alloc refused that cycle, accepted next cycle with tag 0 after wrap.
REQ-042 Depth 5 (non-power-of-two): 12 alloc/complete/retire rounds -> tags wrap 4->0; data order preserved.
REQ-043 Assert rst with 3 entries pending -> next cycle count=0, empty=1, out_valid=0; a completion for old tag 1 raises cpl_err.

Source files
------------

// File: rtl/wrap_ptr.sv
// rtl/wrap_ptr.sv - modulo-depth wrapping pointer
//
// Purpose: pointer register counting 0 .. depth-1 and wrapping back to 0.
//          The wrap is an explicit compare, so any depth >= 2 works,
//          including non-powers of two.
// Ports:
//   clk  - clock, updates on posedge
//   inc  - advance the pointer by one (with wrap)
//   clr  - synchronous clear to 0, wins over inc
//   ptr  - current pointer value, $clog2(depth) bits
module wrap_ptr #(
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(depth)-1:0] ptr
);

  localparam int tag_w = $clog2(depth);
  localparam logic [tag_w-1:0] last = tag_w'(depth - 1);

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == last) ? '0 : ptr + tag_w'(1);
    end
  end

endmodule

// File: rtl/reorder_fifo.sv
// rtl/reorder_fifo.sv - in-order allocate, out-of-order complete, in-order retire
//
// Purpose: entries are allocated in order and receive a tag (slot index).
//          Results arrive out of order by tag; entries leave in allocation
//          order once the head slot has its result.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   alloc_valid/ready/tag - allocation handshake; tag is the slot handed out
//   cpl_valid/tag/data    - completion strobe with slot and result
//   cpl_err               - one-cycle pulse after an illegal completion
//   out_valid/ready       - retire handshake for the head entry
//   out_data/out_tag      - head entry result and slot index
//   count, empty, full    - registered occupancy status
module reorder_fifo #(
  parameter  int width = 8,
  parameter  int depth = 4,
  localparam int tag_w = $clog2(depth),
  localparam int cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [tag_w-1:0] alloc_tag,
  input  logic             cpl_valid,
  input  logic [tag_w-1:0] cpl_tag,
  input  logic [width-1:0] cpl_data,
  output logic             cpl_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [tag_w-1:0] out_tag,
  output logic [cnt_w-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [tag_w-1:0] head;
  logic [tag_w-1:0] tail;
  logic [depth-1:0] done;
  logic [width-1:0] mem [depth];

  logic             alloc_fire;
  logic             retire;
  logic             cpl_in_range;
  logic [31:0]      cpl_off;
  logic             cpl_legal;
  logic [cnt_w-1:0] count_next;

  wrap_ptr #(.depth(depth)) u_head (
    .clk (clk),
    .inc (retire),
    .clr (rst),
    .ptr (head)
  );

  wrap_ptr #(.depth(depth)) u_tail (
    .clk (clk),
    .inc (alloc_fire),
    .clr (rst),
    .ptr (tail)
  );

  // Allocation looks only at registered full: a retire in the same cycle
  // does not free a slot for a simultaneous allocation.
  assign alloc_ready = !full;
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && !full;

  assign out_valid = !empty && done[head];
  assign out_data  = mem[head];
  assign out_tag   = head;
  assign retire    = out_valid && out_ready;

  // A slot is allocated when its distance from head (mod depth) is below
  // count. The head slot of a retiring cycle already has done=1, so it can
  // never be legally completed in that cycle.
  always_comb begin
    cpl_in_range = 32'(cpl_tag) < 32'(depth);
    if (32'(cpl_tag) >= 32'(head)) begin
      cpl_off = 32'(cpl_tag) - 32'(head);
    end else begin
      cpl_off = 32'(cpl_tag) + 32'(depth) - 32'(head);
    end
    cpl_legal = cpl_valid && cpl_in_range && (cpl_off < 32'(count)) && !done[cpl_tag];
  end

  always_comb begin
    count_next = count;
    case ({alloc_fire, retire})
      2'b10:   count_next = count + cnt_w'(1);
      2'b01:   count_next = count - cnt_w'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      done    <= '0;
      cpl_err <= 1'b0;
    end else begin
      count   <= count_next;
      empty   <= (count_next == '0);
      full    <= (count_next == cnt_w'(depth));
      cpl_err <= cpl_valid && !cpl_legal;
      // The three targets are always distinct slots when they fire together.
      if (alloc_fire) done[tail]    <= 1'b0;
      if (retire)     done[head]    <= 1'b0;
      if (cpl_legal)  done[cpl_tag] <= 1'b1;
    end
  end

  // Result storage is deliberately not reset; done bits gate its use.
  always_ff @(posedge clk) begin
    if (!rst && cpl_legal) begin
      mem[cpl_tag] <= cpl_data;
    end
  end

endmodule

// File: tb/tb_reorder_fifo.sv
// tb/tb_reorder_fifo.sv - scoreboard bench for reorder_fifo at depth 4 and depth 5
module tb_reorder_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_v [2];
  logic       c_v [2];
  logic       o_r [2];
  logic [2:0] c_tag [2];
  logic [7:0] c_d [2];

  logic       ar [2];
  logic       er [2];
  logic       ov [2];
  logic       em [2];
  logic       fu [2];
  logic [7:0] od [2];
  logic [2:0] cn [2];
  logic [1:0] at0, ot0;
  logic [2:0] at1, ot1;

  reorder_fifo #(.width(8), .depth(4)) dut4 (
    .clk(clk), .rst(rst),
    .alloc_valid(a_v[0]), .alloc_ready(ar[0]), .alloc_tag(at0),
    .cpl_valid(c_v[0]), .cpl_tag(c_tag[0][1:0]), .cpl_data(c_d[0]), .cpl_err(er[0]),
    .out_valid(ov[0]), .out_ready(o_r[0]), .out_data(od[0]), .out_tag(ot0),
    .count(cn[0]), .empty(em[0]), .full(fu[0])
  );

  reorder_fifo #(.width(8), .depth(5)) dut5 (
    .clk(clk), .rst(rst),
    .alloc_valid(a_v[1]), .alloc_ready(ar[1]), .alloc_tag(at1),
    .cpl_valid(c_v[1]), .cpl_tag(c_tag[1]), .cpl_data(c_d[1]), .cpl_err(er[1]),
    .out_valid(ov[1]), .out_ready(o_r[1]), .out_data(od[1]), .out_tag(ot1),
    .count(cn[1]), .empty(em[1]), .full(fu[1])
  );

  // Reference model: per DUT, the in-order list of live tags, per-tag
  // done flag and result, and the next tag to be handed out.
  typedef struct {
    int tag;
    int data;
  } exp_t;

  int   ord_q [2][$];
  bit   m_done [2][8];
  int   m_data [2][8];
  int   m_tail [2];
  int   m_push [2];
  bit   m_err [2];
  exp_t exp_q [2][$];

  int n_chk = 0;
  int n_fail = 0;

  function automatic int dep(int s);
    return (s == 0) ? 4 : 5;
  endfunction

  function automatic void check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic bit is_live(int s, int t);
    for (int i = 0; i < ord_q[s].size(); i++) begin
      if (ord_q[s][i] == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      ord_q[s].delete();
      exp_q[s].delete();
      for (int t = 0; t < 8; t++) m_done[s][t] = 1'b0;
      m_tail[s] = 0;
      m_push[s] = 0;
      m_err[s]  = 1'b0;
    end
  endfunction

  // Scoreboard consumer: every DUT retirement pops the oldest expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ov[k] === 1'b1 && o_r[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL d%0d retire: got tag %0d data %0d, expected no output",
                   dep(k), (k == 0) ? int'(ot0) : int'(ot1), od[k]);
        end else begin
          mon_e = exp_q[k].pop_front();
          check($sformatf("d%0d out_tag", dep(k)), (k == 0) ? int'(ot0) : int'(ot1), mon_e.tag);
          check($sformatf("d%0d out_data", dep(k)), int'(od[k]), mon_e.data);
        end
      end
    end
  end

  // One cycle on DUT s: compare registered outputs with the model, drive the
  // inputs for the coming edge, and advance the model past that edge.
  task automatic step(int s, bit av, bit cv, int ct, int cd, bit ordy);
    int  d  = dep(s);
    int  sz = ord_q[s].size();
    bit  exp_ov;
    int  exp_ot;
    bit  legal, fire, ret;
    string p = $sformatf("d%0d", d);

    exp_ov = (sz > 0) && m_done[s][ord_q[s][0]];
    exp_ot = (sz > 0) ? ord_q[s][0] : m_tail[s];

    check({p, " count"}, int'(cn[s]), sz);
    check({p, " full"}, int'(fu[s]), int'(sz == d));
    check({p, " empty"}, int'(em[s]), int'(sz == 0));
    check({p, " alloc_ready"}, int'(ar[s]), int'(sz != d));
    check({p, " alloc_tag"}, (s == 0) ? int'(at0) : int'(at1), m_tail[s]);
    check({p, " out_valid"}, int'(ov[s]), int'(exp_ov));
    check({p, " out_tag"}, (s == 0) ? int'(ot0) : int'(ot1), exp_ot);
    check({p, " cpl_err"}, int'(er[s]), int'(m_err[s]));

    a_v[s]   = av;
    c_v[s]   = cv;
    c_tag[s] = 3'(ct);
    c_d[s]   = 8'(cd);
    o_r[s]   = ordy;

    fire  = av && (sz < d);
    legal = cv && (ct < d) && is_live(s, ct) && !m_done[s][ct];
    ret   = exp_ov && ordy;
    m_err[s] = cv && !legal;

    if (ret) begin
      m_done[s][ord_q[s][0]] = 1'b0;
      void'(ord_q[s].pop_front());
      m_push[s]--;
    end
    if (legal) begin
      m_done[s][ct] = 1'b1;
      m_data[s][ct] = cd & 8'hff;
    end
    if (fire) begin
      ord_q[s].push_back(m_tail[s]);
      m_tail[s] = (m_tail[s] + 1) % d;
    end
    // The leading run of completed entries is now guaranteed output order.
    while (m_push[s] < ord_q[s].size() && m_done[s][ord_q[s][m_push[s]]]) begin
      exp_q[s].push_back('{ord_q[s][m_push[s]], m_data[s][ord_q[s][m_push[s]]]});
      m_push[s]++;
    end

    @(posedge clk);
    #1;
    a_v[s] = 1'b0;
    c_v[s] = 1'b0;
    o_r[s] = 1'b0;
  endtask

  // Reset with an allocation and completion requested at the same time:
  // reset must win.
  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      a_v[s] = 1'b1;
      c_v[s] = 1'b1;
      c_tag[s] = 3'd0;
      o_r[s] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      a_v[s] = 1'b0;
      c_v[s] = 1'b0;
    end
    model_reset();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("d%0d reset count", dep(s)), int'(cn[s]), 0);
      check($sformatf("d%0d reset empty", dep(s)), int'(em[s]), 1);
      check($sformatf("d%0d reset full", dep(s)), int'(fu[s]), 0);
      check($sformatf("d%0d reset out_valid", dep(s)), int'(ov[s]), 0);
      check($sformatf("d%0d reset cpl_err", dep(s)), int'(er[s]), 0);
    end
  endtask

  task automatic drain(int s);
    for (int i = 0; i < 40 && ord_q[s].size() > 0; i++) begin
      int ct = -1;
      for (int j = 0; j < ord_q[s].size(); j++) begin
        if (ct < 0 && !m_done[s][ord_q[s][j]]) ct = ord_q[s][j];
      end
      if (ct >= 0) step(s, 1'b0, 1'b1, ct, int'($urandom_range(0, 255)), 1'b1);
      else         step(s, 1'b0, 1'b0, 0, 0, 1'b1);
    end
    step(s, 1'b0, 1'b0, 0, 0, 1'b0);
    check($sformatf("d%0d drained pending", dep(s)), exp_q[s].size(), 0);
  endtask

  task automatic random_run(int s, int cycles);
    for (int i = 0; i < cycles; i++) begin
      int ct;
      if (ord_q[s].size() > 0 && $urandom_range(0, 9) < 7)
        ct = ord_q[s][$urandom_range(0, ord_q[s].size() - 1)];
      else
        ct = int'($urandom_range(0, (s == 0) ? 3 : 7));
      step(s, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, ct,
           int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      a_v[s] = 1'b0; c_v[s] = 1'b0; o_r[s] = 1'b0;
      c_tag[s] = 3'd0; c_d[s] = 8'd0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Depth 4: fill, then an allocation attempt while full is refused.
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(0, 1'b1, 1'b0, 0, 0, 1'b0);
    check("d4 full after 4 allocs", int'(fu[0]), 1);
    check("d4 count after 4 allocs", int'(cn[0]), 4);

    // Out-of-order completion, in-order retirement.
    step(0, 1'b0, 1'b1, 2, 8'h22, 1'b1);
    step(0, 1'b0, 1'b1, 0, 8'h00, 1'b1);
    step(0, 1'b0, 1'b1, 3, 8'h33, 1'b1);
    step(0, 1'b0, 1'b1, 1, 8'h11, 1'b1);
    repeat (4) step(0, 1'b0, 1'b0, 0, 0, 1'b1);

    // Double completion of one tag: the second is ignored and flagged.
    step(0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(0, 1'b0, 1'b1, 1, 8'h5a, 1'b0);
    step(0, 1'b0, 1'b1, 1, 8'ha5, 1'b0);
    step(0, 1'b0, 1'b1, 0, 8'h77, 1'b0);
    repeat (3) step(0, 1'b0, 1'b0, 0, 0, 1'b1);

    // Full with a retiring head: allocation is refused this cycle, next
    // cycle it gets tag 0 after the tail wrapped.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(0, 1'b0, 1'b1, 0, 8'h01, 1'b0);
    step(0, 1'b1, 1'b0, 0, 0, 1'b1);
    check("d4 alloc refused on retire", int'(cn[0]), 3);
    check("d4 wrapped alloc_tag", int'(at0), 0);
    step(0, 1'b1, 1'b0, 0, 0, 1'b0);
    drain(0);

    // Reset with entries pending, then a completion for a stale tag.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(0, 1'b0, 1'b1, 0, 8'h10, 1'b0);
    do_reset();
    step(0, 1'b0, 1'b1, 1, 8'h44, 1'b0);
    step(0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Depth 5: single-entry rounds walk the tags through the 4->0 wrap.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      check("d5 round alloc_tag", int'(at1), r % 5);
      step(1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1, 1'b0, 1'b1, r % 5, (r * 17) & 8'hff, 1'b1);
      step(1, 1'b0, 1'b0, 0, 0, 1'b1);
    end

    // Depth 5 also sees completions with tags 5..7, which are out of range.
    random_run(1, 1500);
    drain(1);
    random_run(0, 1500);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
